// File: rtl/ds1302_responder_if.sv
// Control/status side of the DS1302 3-wire link: CE and SCLK from the master, drive/busy back.
// The bidirectional IO line stays a plain inout on the responder.
interface ds1302_responder_if;
    logic i_ce;
    logic i_sclk;
    logic o_drive;
    logic o_busy;

    modport master (output i_ce, output i_sclk, input o_drive, input o_busy);
    modport slave  (input i_ce, input i_sclk, output o_drive, output o_busy);
endinterface

// File: rtl/ds1302_responder.sv
// DS1302 device-side emulation: single-byte clock-register reads/writes over CE/SCLK/IO,
// plus an internal BCD calendar advanced by a divided one-second tick.
module ds1302_responder #(
    parameter int TICK_DIV = 100_000_000
) (
    input  logic              clk,
    input  logic              reset_p,
    ds1302_responder_if.slave bus,
    inout  wire               io
);
    localparam int DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_CMD    = 3'd1;
    localparam logic [2:0] S_WDATA  = 3'd2;
    localparam logic [2:0] S_RDATA  = 3'd3;
    localparam logic [2:0] S_IGNORE = 3'd4;

    // bit 0 = CE, bit 1 = SCLK, bit 2 = IO
    logic [2:0] raw_in, meta_reg, sync_reg;
    logic       ce_d_reg, sclk_d_reg;
    logic       ce_rise, ce_fall, sclk_rise, sclk_fall, io_s;

    logic [2:0] state_reg;
    logic [3:0] bit_cnt_reg;
    logic [7:0] shift_reg, shift_in;
    logic [5:0] tgt_reg;
    logic       drive_reg, io_out_reg, busy_reg;

    logic [7:0] sec_reg, min_reg, hr_reg, date_reg, month_reg, day_reg, year_reg;
    logic       wp_reg;
    logic [DIV_W-1:0] div_reg;

    logic [7:0] rd_value;
    logic       writable, wr_en;
    logic       tick, c_min, c_hr, c_day, c_mon, c_yr;

    assign raw_in = {io, bus.i_sclk, bus.i_ce};

    always_ff @(posedge clk or posedge reset_p) begin
        if (reset_p) begin
            meta_reg <= '0;
            sync_reg <= '0;
        end else begin
            meta_reg <= raw_in;
            sync_reg <= meta_reg;
        end
    end

    assign ce_rise   =  sync_reg[0] & ~ce_d_reg;
    assign ce_fall   = ~sync_reg[0] &  ce_d_reg;
    assign sclk_rise =  sync_reg[1] & ~sclk_d_reg;
    assign sclk_fall = ~sync_reg[1] &  sclk_d_reg;
    assign io_s      =  sync_reg[2];
    assign shift_in  = {io_s, shift_reg[7:1]};

    function automatic logic [7:0] bcd_inc(input logic [7:0] v);
        if (v[3:0] >= 4'd9) bcd_inc = {v[7:4] + 4'd1, 4'd0};
        else                bcd_inc = {v[7:4], v[3:0] + 4'd1};
    endfunction

    // Read data is taken from the command as it completes, so a tick after the 8th rise cannot alter it.
    always_comb begin
        rd_value = 8'h00;
        if (!shift_in[6] && shift_in[5:4] == 2'b00) begin
            case (shift_in[3:1])
                3'd0:    rd_value = sec_reg;
                3'd1:    rd_value = min_reg;
                3'd2:    rd_value = hr_reg;
                3'd3:    rd_value = date_reg;
                3'd4:    rd_value = month_reg;
                3'd5:    rd_value = day_reg;
                3'd6:    rd_value = year_reg;
                default: rd_value = {wp_reg, 7'b0};
            endcase
        end
    end

    assign writable = !tgt_reg[5] && tgt_reg[4:3] == 2'b00 && (tgt_reg[2:0] == 3'd7 || !wp_reg);
    assign wr_en    = (state_reg == S_WDATA) && sclk_rise && !ce_fall
                      && (bit_cnt_reg == 4'd15) && writable;

    always_ff @(posedge clk or posedge reset_p) begin
        if (reset_p) begin
            ce_d_reg    <= 1'b0;
            sclk_d_reg  <= 1'b0;
            state_reg   <= S_IDLE;
            bit_cnt_reg <= '0;
            shift_reg   <= '0;
            tgt_reg     <= '0;
            drive_reg   <= 1'b0;
            io_out_reg  <= 1'b0;
            busy_reg    <= 1'b0;
        end else begin
            ce_d_reg   <= sync_reg[0];
            sclk_d_reg <= sync_reg[1];
            if (ce_rise)      busy_reg <= 1'b1;
            else if (ce_fall) busy_reg <= 1'b0;

            if (ce_fall) begin
                state_reg <= S_IDLE;
                drive_reg <= 1'b0;
            end else begin
                case (state_reg)
                    S_IDLE: if (ce_rise) begin
                        state_reg   <= S_CMD;
                        bit_cnt_reg <= '0;
                    end
                    S_CMD: if (sclk_rise) begin
                        shift_reg   <= shift_in;
                        bit_cnt_reg <= bit_cnt_reg + 4'd1;
                        if (bit_cnt_reg == 4'd7) begin
                            tgt_reg <= shift_in[6:1];
                            if (!shift_in[7]) begin
                                state_reg <= S_IGNORE;
                            end else if (shift_in[0]) begin
                                state_reg <= S_RDATA;
                                shift_reg <= rd_value;
                            end else begin
                                state_reg <= S_WDATA;
                            end
                        end
                    end
                    S_WDATA: if (sclk_rise) begin
                        shift_reg   <= shift_in;
                        bit_cnt_reg <= bit_cnt_reg + 4'd1;
                        if (bit_cnt_reg == 4'd15) state_reg <= S_IGNORE;
                    end
                    // MSB is replicated on shift so IO keeps bit7 once the byte is out.
                    S_RDATA: if (sclk_fall) begin
                        drive_reg  <= 1'b1;
                        io_out_reg <= shift_reg[0];
                        shift_reg  <= {shift_reg[7], shift_reg[7:1]};
                    end
                    default: ;
                endcase
            end
        end
    end

    assign tick  = !sec_reg[7] && (div_reg == DIV_LAST);
    assign c_min = tick  && sec_reg[6:0] == 7'h59;
    assign c_hr  = c_min && min_reg == 8'h59;
    assign c_day = c_hr  && hr_reg == 8'h23;
    assign c_mon = c_day && date_reg == 8'h31;
    assign c_yr  = c_mon && month_reg == 8'h12;

    // Calendar update first, then a committed write overrides its own register only.
    always_ff @(posedge clk or posedge reset_p) begin
        if (reset_p) begin
            div_reg   <= '0;
            sec_reg   <= 8'h00;
            min_reg   <= 8'h00;
            hr_reg    <= 8'h00;
            date_reg  <= 8'h01;
            month_reg <= 8'h01;
            day_reg   <= 8'h01;
            year_reg  <= 8'h00;
            wp_reg    <= 1'b1;
        end else begin
            if (wr_en && tgt_reg[2:0] == 3'd0) div_reg <= '0;
            else if (!sec_reg[7])              div_reg <= (div_reg == DIV_LAST) ? '0 : div_reg + DIV_W'(1);

            if (tick)  sec_reg   <= c_min ? 8'h00 : bcd_inc(sec_reg);
            if (c_min) min_reg   <= c_hr  ? 8'h00 : bcd_inc(min_reg);
            if (c_hr)  hr_reg    <= c_day ? 8'h00 : bcd_inc(hr_reg);
            if (c_day) date_reg  <= c_mon ? 8'h01 : bcd_inc(date_reg);
            if (c_day) day_reg   <= (day_reg == 8'h07) ? 8'h01 : day_reg + 8'h01;
            if (c_mon) month_reg <= c_yr  ? 8'h01 : bcd_inc(month_reg);
            if (c_yr)  year_reg  <= (year_reg == 8'h99) ? 8'h00 : bcd_inc(year_reg);

            if (wr_en) begin
                case (tgt_reg[2:0])
                    3'd0:    sec_reg   <= shift_in;
                    3'd1:    min_reg   <= {1'b0, shift_in[6:0]};
                    3'd2:    hr_reg    <= {2'b0, shift_in[5:0]};
                    3'd3:    date_reg  <= {2'b0, shift_in[5:0]};
                    3'd4:    month_reg <= {3'b0, shift_in[4:0]};
                    3'd5:    day_reg   <= {5'b0, shift_in[2:0]};
                    3'd6:    year_reg  <= shift_in;
                    default: wp_reg    <= shift_in[7];
                endcase
            end
        end
    end

    assign bus.o_drive = drive_reg;
    assign bus.o_busy  = busy_reg;
    assign io          = drive_reg ? io_out_reg : 1'bz;
endmodule

// File: tb/tb_ds1302_responder.sv
// Directed bench: plays the DS1302 master on CE/SCLK/IO and checks register reads, writes,
// write protect, calendar rollover, clock halt, command rejection, aborts and reset.
`timescale 1ns/1ps
module tb_ds1302_responder;
    localparam int TICK = 16;
    localparam int HP   = 6;

    logic clk = 1'b0;
    logic reset_p = 1'b1;
    logic io_en = 1'b0;
    logic io_val = 1'b0;
    wire  io;
    int   cyc;
    int   total = 0;
    int   bad = 0;
    int   last_rise = 0;
    int   last_commit = 0;
    int   epoch = 0;

    ds1302_responder_if bus();

    ds1302_responder #(.TICK_DIV(TICK)) dut (
        .clk    (clk),
        .reset_p(reset_p),
        .bus    (bus),
        .io     (io)
    );

    assign io = io_en ? io_val : 1'bz;

    always #5 clk = ~clk;

    // Counts clock edges since the last reset release; seconds are derived from it.
    always @(posedge clk) begin
        if (reset_p) cyc <= 0;
        else         cyc <= cyc + 1;
    end

    function automatic logic [7:0] to_bcd(input int v);
        to_bcd = {4'(v / 10), 4'(v % 10)};
    endfunction

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic send_bits(input logic [7:0] b, input int n);
        for (int i = 0; i < n; i++) begin
            io_en = 1'b1;
            io_val = b[i];
            step(HP);
            bus.i_sclk = 1'b1;
            last_rise = cyc;
            step(HP);
            bus.i_sclk = 1'b0;
        end
        io_en = 1'b0;
    endtask

    task automatic stop_txn(input string tag);
        step(HP);
        bus.i_ce = 1'b0;
        step(8);
        check({tag, "_drv_off"}, {7'b0, bus.o_drive}, 8'h00);
        check({tag, "_busy_off"}, {7'b0, bus.o_busy}, 8'h00);
    endtask

    task automatic write_byte(input logic [7:0] cmd, input logic [7:0] data, input int nbits);
        bus.i_ce = 1'b1;
        step(HP);
        send_bits(cmd, 8);
        send_bits(data, nbits);
        last_commit = last_rise + 3;
        stop_txn("wr");
    endtask

    task automatic read_check(input string tag, input logic [7:0] cmd,
                              input logic [7:0] exp, input logic exp_drv);
        logic [7:0] data;
        bus.i_ce = 1'b1;
        step(HP);
        check({tag, "_busy"}, {7'b0, bus.o_busy}, 8'h01);
        send_bits(cmd, 8);
        step(2);
        check({tag, "_drv_early"}, {7'b0, bus.o_drive}, 8'h00);
        step(1);
        check({tag, "_drv_rise"}, {7'b0, bus.o_drive}, {7'b0, exp_drv});
        step(HP - 3);
        data = 8'h00;
        data[0] = io;
        for (int j = 1; j < 8; j++) begin
            bus.i_sclk = 1'b1;
            step(HP);
            bus.i_sclk = 1'b0;
            step(HP);
            data[j] = io;
        end
        if (exp_drv) begin
            check(tag, data, exp);
            bus.i_sclk = 1'b1;
            step(HP);
            bus.i_sclk = 1'b0;
            step(HP);
            check({tag, "_hold7"}, {7'b0, io}, {7'b0, exp[7]});
        end else begin
            check({tag, "_drv_low"}, {7'b0, bus.o_drive}, 8'h00);
        end
        stop_txn(tag);
    endtask

    // Reads SEC with the sample point placed mid-second relative to the last divider restart.
    task automatic read_sec(input string tag, input int base);
        int n;
        while (((cyc + 98 - epoch) % TICK) != 8) step(1);
        n = (cyc + 98 - epoch) / TICK;
        read_check(tag, 8'h81, to_bcd((base + n) % 60), 1'b1);
    endtask

    initial begin
        bus.i_ce = 1'b0;
        bus.i_sclk = 1'b0;
        step(3);
        reset_p = 1'b0;
        epoch = 0;
        step(1);
        check("rst_drive", {7'b0, bus.o_drive}, 8'h00);
        check("rst_busy", {7'b0, bus.o_busy}, 8'h00);

        read_sec("rst_sec", 0);
        write_byte(8'h80, 8'h45, 8);
        read_sec("wp_sec", 0);
        read_check("rst_ctrl", 8'h8F, 8'h80, 1'b1);
        read_check("rst_date", 8'h87, 8'h01, 1'b1);

        write_byte(8'h8E, 8'h00, 8);
        read_check("wp_clr", 8'h8F, 8'h00, 1'b1);
        write_byte(8'h80, 8'h45, 8);
        epoch = last_commit;
        read_sec("sec_wr", 45);

        write_byte(8'h80, 8'hD9, 8);
        write_byte(8'h82, 8'h59, 8);
        write_byte(8'h84, 8'h23, 8);
        write_byte(8'h86, 8'h31, 8);
        write_byte(8'h88, 8'h12, 8);
        write_byte(8'h8C, 8'h99, 8);
        write_byte(8'h8A, 8'h07, 8);
        read_check("pre_hr", 8'h85, 8'h23, 1'b1);
        write_byte(8'h80, 8'h59, 8);
        write_byte(8'h80, 8'h80, 8);
        read_check("roll_min", 8'h83, 8'h00, 1'b1);
        read_check("roll_hr", 8'h85, 8'h00, 1'b1);
        read_check("roll_date", 8'h87, 8'h01, 1'b1);
        read_check("roll_month", 8'h89, 8'h01, 1'b1);
        read_check("roll_year", 8'h8D, 8'h00, 1'b1);
        read_check("roll_day", 8'h8B, 8'h01, 1'b1);

        step(100);
        read_check("ch_hold", 8'h81, 8'h80, 1'b1);
        write_byte(8'h80, 8'h10, 8);
        epoch = last_commit;
        read_sec("sec_run", 10);

        write_byte(8'h80, 8'hA0, 8);
        read_check("bit7_rd", 8'h01, 8'h00, 1'b0);
        write_byte(8'h00, 8'h33, 8);
        read_check("bit7_wr", 8'h81, 8'hA0, 1'b1);
        write_byte(8'h82, 8'h27, 4);
        read_check("abort_min", 8'h83, 8'h00, 1'b1);
        read_check("ram_rd", 8'hC1, 8'h00, 1'b1);
        write_byte(8'h8C, 8'h42, 8);
        read_check("year_wr", 8'h8D, 8'h42, 1'b1);

        bus.i_ce = 1'b1;
        step(HP);
        send_bits(8'h8F, 8);
        step(4);
        check("mid_drv_on", {7'b0, bus.o_drive}, 8'h01);
        reset_p = 1'b1;
        bus.i_ce = 1'b0;
        #1;
        check("mid_rst_drv", {7'b0, bus.o_drive}, 8'h00);
        step(2);
        reset_p = 1'b0;
        epoch = 0;
        step(4);
        read_check("rst2_ctrl", 8'h8F, 8'h80, 1'b1);
        read_check("rst2_year", 8'h8D, 8'h00, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
